// File: rtl/genfifo_rctl.sv
// Read-side controller of the dual-clock generic FIFO: read pointer, write-pointer sync, empty/level/underflow.
// Optional level logic (rlevel, almost_empty) is built only when GENFIFO_RCTL_LEVEL_EN is defined.
module genfifo_rctl #(
    parameter int addr_width  = 8,
    parameter int sync_stages = 2,
    parameter int ae_thresh   = 4
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  re,
    input  logic [addr_width:0]   wptr_gray,
    output logic [addr_width-1:0] raddr,
    output logic                  oe,
    output logic [addr_width:0]   rptr_gray,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [addr_width:0]   rlevel,
    output logic                  underflow
);

    localparam int PW = addr_width + 1;

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rgray_q, rgray_d;
    logic [PW-1:0] sync_q [sync_stages];
    logic [PW-1:0] wsync;
    logic          empty_q, empty_d;
    logic          underflow_q, underflow_d;
    logic          pop;

    assign wsync = sync_q[sync_stages-1];
    assign pop   = re & ~empty_q;

    always_comb begin
        rbin_d      = rbin_q + {{(PW-1){1'b0}}, pop};
        rgray_d     = rbin_d ^ (rbin_d >> 1);
        empty_d     = (rgray_d == wsync);
        underflow_d = underflow_q | (re & empty_q);
    end

    // Plain flop chain: each Gray step flips one bit, so any stage sees either old or new pointer.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            for (int i = 0; i < sync_stages; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= wptr_gray;
            for (int i = 1; i < sync_stages; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rbin_q      <= '0;
            rgray_q     <= '0;
            empty_q     <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            rbin_q      <= rbin_d;
            rgray_q     <= rgray_d;
            empty_q     <= empty_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef GENFIFO_RCTL_LEVEL_EN
    logic [PW-1:0] wbin;
    logic [PW-1:0] rlevel_q, rlevel_d;
    logic          ae_q, ae_d;

    always_comb begin
        for (int i = 0; i < PW; i++) wbin[i] = ^(wsync >> i);
        rlevel_d = wbin - rbin_d;
        ae_d     = (rlevel_d <= PW'(ae_thresh));
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rlevel_q <= '0;
            ae_q     <= 1'b1;
        end else begin
            rlevel_q <= rlevel_d;
            ae_q     <= ae_d;
        end
    end

    assign rlevel       = rlevel_q;
    assign almost_empty = ae_q;
`else
    assign rlevel       = '0;
    assign almost_empty = 1'b0;
`endif

    assign raddr     = rbin_q[addr_width-1:0];
    assign rptr_gray = rgray_q;
    assign empty     = empty_q;
    assign oe        = ~empty_q;
    assign underflow = underflow_q;

endmodule
